mem_access_stage: RTL and testbench

Parametrised MEM stage with MEM/WB pipeline register for the RISC-V pipeline. It owns a byte-addressable little-endian data memory and supports B/H/W/D stores and sign- or zero-extended loads. Memory latency is configurable; while an access is in flight the block stalls upstream with StallM.

---
 rtl/mem_access_stage.sv | 101 ++++++++++
 tb/tb_mem_access_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage with MEM/WB register and MEM_LAT-cycle data memory; define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage #(
    parameter int XLEN      = 64,
    parameter int MEM_DEPTH = 512,
    parameter int MEM_LAT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic            RegWriteEnM,
    input  logic            MemtoRegM,
    input  logic            JALM,
    input  logic            MemReadEnM,
    input  logic            MemWriteEnM,
    input  logic [1:0]      MemSizeM,
    input  logic            LoadUnsignedM,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] PcPlus4M,
    input  logic [XLEN-1:0] ReadData2M,
    input  logic [XLEN-1:0] ALUResultM,
    output logic            StallM,
    output logic            ValidW,
    output logic            RegWriteEnW,
    output logic            MemtoRegW,
    output logic            JALW,
    output logic [XLEN-1:0] PcPlus4W,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [4:0]      RdW,
    output logic            MisalignW
);
    localparam int OFF = $clog2(XLEN / 8);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int CW  = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    typedef enum logic {IDLE, ACCESS} stateT;
    stateT           state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] mem [MEM_DEPTH];
    logic [IW-1:0]   idx;
    logic [OFF-1:0]  byteOff, offM, sizeM1;
    logic [6:0]      sizeBits;
    logic [XLEN-1:0] lenMask, laneMask, rawData, loadData;
    logic            memReq, illegal, fault, memOp, done;
    always_comb begin
        idx      = ALUResultM[OFF +: IW];
        byteOff  = ALUResultM[OFF-1:0];
        sizeM1   = OFF'((4'd1 << MemSizeM) - 4'd1);
        sizeBits = 7'd8 << MemSizeM;
        memReq   = ValidM && (MemReadEnM || MemWriteEnM);
        illegal  = (XLEN == 32) && (MemSizeM == 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
        fault    = memReq && (illegal || |(byteOff & sizeM1));
        offM     = byteOff;
`else
        fault    = memReq && illegal;
        offM     = byteOff & ~sizeM1;
`endif
        memOp    = memReq && !fault;
        lenMask  = ~({XLEN{1'b1}} << sizeBits);
        laneMask = lenMask << {offM, 3'b000};
        rawData  = mem[idx] >> {offM, 3'b000};
        // top bit of lenMask picks the sign bit of the extracted lanes
        loadData = (rawData & lenMask) |
                   ((!LoadUnsignedM && |(rawData & (lenMask ^ (lenMask >> 1)))) ? ~lenMask : '0);
        done     = (state == IDLE) ? !(memOp && MEM_LAT > 1) : (cnt == '0);
        StallM   = !rst && !done;
    end
    always_ff @(posedge clk) begin
        if (!rst && done && memOp && MemWriteEnM)
            mem[idx] <= (mem[idx] & ~laneMask) | ((ReadData2M << {offM, 3'b000}) & laneMask);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ValidW      <= 1'b0;
            RegWriteEnW <= 1'b0;
            MemtoRegW   <= 1'b0;
            JALW        <= 1'b0;
            PcPlus4W    <= '0;
            ALUResultW  <= '0;
            ReadDataW   <= '0;
            RdW         <= '0;
            MisalignW   <= 1'b0;
        end else begin
            state       <= done ? IDLE : ACCESS;
            cnt         <= (state == IDLE) ? CW'(MEM_LAT - 2) : cnt - 1'b1;
            ValidW      <= done && ValidM;
            RegWriteEnW <= done && ValidM && RegWriteEnM && !fault;
            if (done) begin
                MemtoRegW  <= MemtoRegM;
                JALW       <= JALM;
                PcPlus4W   <= PcPlus4M;
                ALUResultW <= ALUResultM;
                ReadDataW  <= (memOp && MemReadEnM) ? loadData : '0;
                RdW        <= RdM;
                MisalignW  <= fault;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench for mem_access_stage at XLEN=64, MEM_DEPTH=512, MEM_LAT=2.
module tb_mem_access_stage;
    logic        clk, rst;
    logic        ValidM, RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM, LoadUnsignedM;
    logic [1:0]  MemSizeM;
    logic [4:0]  RdM, RdW;
    logic [63:0] PcPlus4M, ReadData2M, ALUResultM, PcPlus4W, ALUResultW, ReadDataW;
    logic        StallM, ValidW, RegWriteEnW, MemtoRegW, JALW, MisalignW;
    int          passed = 0, total = 0;
    mem_access_stage #(.XLEN(64), .MEM_DEPTH(512), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM),
        .JALM(JALM), .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM), .MemSizeM(MemSizeM),
        .LoadUnsignedM(LoadUnsignedM), .RdM(RdM), .PcPlus4M(PcPlus4M), .ReadData2M(ReadData2M),
        .ALUResultM(ALUResultM), .StallM(StallM), .ValidW(ValidW), .RegWriteEnW(RegWriteEnW),
        .MemtoRegW(MemtoRegW), .JALW(JALW), .PcPlus4W(PcPlus4W), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .MisalignW(MisalignW)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask
    task automatic clearIn();
        ValidM = 0; RegWriteEnM = 0; MemtoRegM = 0; JALM = 0; MemReadEnM = 0; MemWriteEnM = 0;
        MemSizeM = 0; LoadUnsignedM = 0; RdM = 0; PcPlus4M = 0; ReadData2M = 0; ALUResultM = 0;
    endtask
    // Called at a negedge; returns at the negedge after completion with W outputs valid.
    task automatic doOp(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] data, input string tag);
        ValidM = 1; RegWriteEnM = rd; MemtoRegM = rd; JALM = 0; MemReadEnM = rd; MemWriteEnM = wr;
        MemSizeM = sz; LoadUnsignedM = uns; RdM = 5'd7; ALUResultM = addr; ReadData2M = data;
        PcPlus4M = 64'h200;
        #1 chk({tag, " stall accept"}, 64'(StallM), 64'd1);
        @(negedge clk);
        chk({tag, " stall drop"}, 64'(StallM), 64'd0);
        chk({tag, " bubble"}, 64'(ValidW), 64'd0);
        @(negedge clk);
        chk({tag, " valid"}, 64'(ValidW), 64'd1);
        chk({tag, " regwrite"}, 64'(RegWriteEnW), 64'(rd));
    endtask
    initial begin
        rst = 1;
        clearIn();
        @(negedge clk);
        chk("rst ValidW", 64'(ValidW), 0);
        chk("rst StallM", 64'(StallM), 0);
        chk("rst RegWriteEnW", 64'(RegWriteEnW), 0);
        chk("rst ReadDataW", ReadDataW, 0);
        chk("rst MisalignW", 64'(MisalignW), 0);
        rst = 0;
        ValidM = 1; RegWriteEnM = 1; JALM = 1; ALUResultM = 64'h1234; RdM = 5'd5; PcPlus4M = 64'h100;
        #1 chk("alu stall", 64'(StallM), 0);
        @(negedge clk);
        chk("alu ValidW", 64'(ValidW), 1);
        chk("alu ALUResultW", ALUResultW, 64'h1234);
        chk("alu RdW", 64'(RdW), 5);
        chk("alu JALW", 64'(JALW), 1);
        chk("alu PcPlus4W", PcPlus4W, 64'h100);
        chk("alu RegWriteEnW", 64'(RegWriteEnW), 1);
        chk("alu ReadDataW", ReadDataW, 0);
        clearIn();
        @(negedge clk);
        chk("invalid ValidW", 64'(ValidW), 0);
        chk("invalid RegWriteEnW", 64'(RegWriteEnW), 0);
        doOp(0, 1, 2'b00, 0, 64'h10, 64'hAA, "sb");
        doOp(1, 0, 2'b00, 0, 64'h10, 0, "lb");
        chk("lb data", ReadDataW, 64'hFFFF_FFFF_FFFF_FFAA);
        doOp(1, 0, 2'b00, 1, 64'h10, 0, "lbu");
        chk("lbu data", ReadDataW, 64'h0000_0000_0000_00AA);
        doOp(0, 1, 2'b10, 0, 64'h30, 64'hAABBCCDD, "sw");
        doOp(1, 0, 2'b01, 0, 64'h32, 0, "lh");
        chk("lh data", ReadDataW, 64'hFFFF_FFFF_FFFF_AABB);
        doOp(1, 0, 2'b10, 0, 64'h30, 0, "lw");
        chk("lw data", ReadDataW, 64'hFFFF_FFFF_AABB_CCDD);
        doOp(1, 0, 2'b10, 1, 64'h30, 0, "lwu");
        chk("lwu data", ReadDataW, 64'h0000_0000_AABB_CCDD);
        doOp(0, 1, 2'b11, 0, 64'h40, 64'h1122334455667788, "sd");
        doOp(0, 1, 2'b00, 0, 64'h43, 64'h0, "sb43");
        doOp(1, 0, 2'b11, 0, 64'h40, 0, "ld40");
        chk("ld40 data", ReadDataW, 64'h1122334400667788);
        doOp(0, 1, 2'b11, 0, 64'h1000, 64'h5, "sd wrap");
        doOp(1, 0, 2'b11, 0, 64'h0, 0, "ld wrap");
        chk("ld wrap data", ReadDataW, 64'h5);
`ifdef MEM_MISALIGN_TRAP_EN
        ValidM = 1; RegWriteEnM = 1; MemtoRegM = 1; MemReadEnM = 1; MemWriteEnM = 0;
        MemSizeM = 2'b10; LoadUnsignedM = 0; ALUResultM = 64'h31;
        #1 chk("lw31 stall", 64'(StallM), 0);
        @(negedge clk);
        chk("lw31 ValidW", 64'(ValidW), 1);
        chk("lw31 MisalignW", 64'(MisalignW), 1);
        chk("lw31 RegWriteEnW", 64'(RegWriteEnW), 0);
        chk("lw31 ReadDataW", ReadDataW, 0);
`else
        doOp(1, 0, 2'b10, 0, 64'h31, 0, "lw31");
        chk("lw31 data", ReadDataW, 64'hFFFF_FFFF_AABB_CCDD);
        chk("lw31 MisalignW", 64'(MisalignW), 0);
`endif
        doOp(0, 1, 2'b11, 0, 64'h50, 64'h77, "sd50 old");
        ValidM = 1; RegWriteEnM = 0; MemtoRegM = 0; MemReadEnM = 0; MemWriteEnM = 1;
        MemSizeM = 2'b11; ALUResultM = 64'h50; ReadData2M = 64'hFF; PcPlus4M = 64'h300;
        @(negedge clk);
        rst = 1;
        #1;
        chk("abort ValidW", 64'(ValidW), 0);
        chk("abort StallM", 64'(StallM), 0);
        chk("abort ALUResultW", ALUResultW, 0);
        chk("abort PcPlus4W", PcPlus4W, 0);
        @(negedge clk);
        rst = 0;
        clearIn();
        doOp(1, 0, 2'b11, 0, 64'h50, 0, "ld50");
        chk("ld50 data", ReadDataW, 64'h77);
        clearIn();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
